// File: rtl/fwd_replicator.sv
// fwd_replicator: replicates framed ingress words to the TX-FIFOs selected by a per-frame snapshot mask.
// Optional frame statistics counters are compiled in with FWD_REPLICATOR_STATS_EN.
module fwd_replicator #(
    parameter int PORT_ID = 0,
    parameter int MAX_LEN = 1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [8:0]  rx_dout,
    input  logic        rx_empty,
    output logic        rx_rd_en,
    input  logic [15:0] cmd_fwd_port,
    input  logic [3:0]  tx_afull,
    output logic [8:0]  tx_din,
    output logic [3:0]  tx_wr_en
`ifdef FWD_REPLICATOR_STATS_EN
    ,
    output logic [15:0] stat_fwd,
    output logic [15:0] stat_drop,
    output logic [15:0] stat_trunc
`endif
);
    typedef enum logic [1:0] {SYNC, IDLE, FWD, DROP} state_t;
    localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);
    state_t      state, state_nx;
    logic [10:0] len, len_nx;
    logic [3:0]  mask, mask_nx, admit, wr_nx;
    logic [8:0]  din_nx;
    logic        vld, trunc, term, drop_ev;
    logic        unused_cmd;
    // Read is gated by reset so nothing is consumed while the block is held in reset.
    assign rx_rd_en   = sys_rst_n & ~rx_empty;
    assign vld        = rx_rd_en;
    assign admit      = cmd_fwd_port[PORT_ID*4 +: 4] & ~tx_afull;
    assign unused_cmd = ^cmd_fwd_port;
    assign trunc      = (state == FWD) && vld && rx_dout[8] && (len == LEN_MAX);
    assign term       = (state == FWD) && vld && (!rx_dout[8] || trunc);
    assign drop_ev    = (state == IDLE) && vld && rx_dout[8] && (admit == 4'h0);
    always_comb begin
        state_nx = state;
        len_nx   = len;
        mask_nx  = mask;
        wr_nx    = 4'h0;
        din_nx   = tx_din;
        case (state)
            SYNC: if (vld && !rx_dout[8]) state_nx = IDLE;
            IDLE: begin
                len_nx = 11'd0;
                if (vld && rx_dout[8]) begin
                    mask_nx  = admit;
                    state_nx = (admit != 4'h0) ? FWD : DROP;
                    wr_nx    = admit;
                    din_nx   = (admit != 4'h0) ? rx_dout : tx_din;
                    len_nx   = (admit != 4'h0) ? 11'd1 : 11'd0;
                end
            end
            FWD: if (vld) begin
                wr_nx    = mask;
                din_nx   = trunc ? 9'h000 : rx_dout;
                len_nx   = (rx_dout[8] && !trunc) ? len + 11'd1 : len;
                state_nx = trunc ? DROP : (rx_dout[8] ? FWD : IDLE);
            end
            default: if (vld && !rx_dout[8]) state_nx = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= SYNC;
            len      <= 11'd0;
            mask     <= 4'h0;
            tx_din   <= 9'h000;
            tx_wr_en <= 4'h0;
        end else begin
            state    <= state_nx;
            len      <= len_nx;
            mask     <= mask_nx;
            tx_din   <= din_nx;
            tx_wr_en <= wr_nx;
        end
    end
`ifdef FWD_REPLICATOR_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_fwd   <= 16'h0000;
            stat_drop  <= 16'h0000;
            stat_trunc <= 16'h0000;
        end else begin
            stat_fwd   <= stat_fwd + {15'd0, term & ~&stat_fwd};
            stat_drop  <= stat_drop + {15'd0, drop_ev & ~&stat_drop};
            stat_trunc <= stat_trunc + {15'd0, trunc & ~&stat_trunc};
        end
    end
`else
    logic unused_stats;
    assign unused_stats = term ^ drop_ev;
`endif
endmodule

// File: tb/tb_fwd_replicator.sv
// tb_fwd_replicator: two replicator instances (port 0 / MAX_LEN 64, port 2 / default length) on one stream,
// checked against a frame-level expectation of which words reach which TX ports.
module tb_fwd_replicator;
    localparam int LA = 64;
    localparam int LB = 1518;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [8:0]  rx_dout = 9'h000;
    logic        rx_empty = 1'b1;
    logic [15:0] cmd_fwd_port = 16'h0000;
    logic [3:0]  tx_afull = 4'h0;
    logic        rd_a, rd_b;
    logic [8:0]  din_a, din_b;
    logic [3:0]  wr_a, wr_b;
    logic        o_rd_a, o_rd_b;
    logic [8:0]  o_da, o_db;
    logic [3:0]  o_wa, o_wb;
    int          cnt_a[4], cnt_b[4];
    int          n_chk = 0, n_fail = 0;
    logic        syncing = 1'b1;
`ifdef FWD_REPLICATOR_STATS_EN
    logic [15:0] sf_a, sd_a, st_a, sf_b, sd_b, st_b;
    logic [15:0] s_fwd_a, s_drop_a, s_trunc_a, s_fwd_b, s_drop_b, s_trunc_b;
`endif

    always #5 sys_clk = ~sys_clk;

    fwd_replicator #(.PORT_ID(0), .MAX_LEN(LA)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_dout(rx_dout), .rx_empty(rx_empty),
        .rx_rd_en(rd_a), .cmd_fwd_port(cmd_fwd_port), .tx_afull(tx_afull),
        .tx_din(din_a), .tx_wr_en(wr_a)
`ifdef FWD_REPLICATOR_STATS_EN
        , .stat_fwd(s_fwd_a), .stat_drop(s_drop_a), .stat_trunc(s_trunc_a)
`endif
    );

    fwd_replicator #(.PORT_ID(2)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_dout(rx_dout), .rx_empty(rx_empty),
        .rx_rd_en(rd_b), .cmd_fwd_port(cmd_fwd_port), .tx_afull(tx_afull),
        .tx_din(din_b), .tx_wr_en(wr_b)
`ifdef FWD_REPLICATOR_STATS_EN
        , .stat_fwd(s_fwd_b), .stat_drop(s_drop_b), .stat_trunc(s_trunc_b)
`endif
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // One clock cycle: drive at the falling edge, sample read strobe before and writes after the rising edge.
    task automatic cyc(input logic [8:0] w, input logic e);
        rx_dout = w;
        rx_empty = e;
        #1;
        o_rd_a = rd_a;
        o_rd_b = rd_b;
        @(posedge sys_clk);
        #1;
        o_wa = wr_a; o_da = din_a;
        o_wb = wr_b; o_db = din_b;
        for (int p = 0; p < 4; p++) begin
            cnt_a[p] += int'(o_wa[p]);
            cnt_b[p] += int'(o_wb[p]);
        end
        @(negedge sys_clk);
    endtask

    task automatic clear_cnt();
        for (int p = 0; p < 4; p++) begin
            cnt_a[p] = 0;
            cnt_b[p] = 0;
        end
    endtask

    // Sends n bytes, a terminator and extra gap words; expectations derive from the frame-start mask and MAX_LEN.
    task automatic send_frame(input int n, input int pe, input int gaps, input int chg_at,
                              input logic [15:0] cv, input logic [3:0] av, input int rst_at);
        logic [3:0] ma, mb, ea, eb;
        logic [8:0] w, xa, xb;
        logic       sy;
        sy = syncing;
        ma = sy ? 4'h0 : cmd_fwd_port[3:0] & ~tx_afull;
        mb = sy ? 4'h0 : cmd_fwd_port[11:8] & ~tx_afull;
        for (int i = 0; i <= n + gaps; i++) begin
            if (i == rst_at) begin
                rx_empty = 1'b0;
                #1 sys_rst_n = 1'b0;
                #1;
                n_chk++;
                if ({rd_a, rd_b, wr_a, wr_b, din_a, din_b} !== 28'h0) begin
                    n_fail++;
                    $display("FAIL reset_mid i=%0d got rd=%b%b wr=%h/%h din=%h/%h want all zero",
                             i, rd_a, rd_b, wr_a, wr_b, din_a, din_b);
                end
                rx_empty = 1'b1;
                #1 sys_rst_n = 1'b1;
                @(negedge sys_clk);
                sy = 1'b1;
                ma = 4'h0;
                mb = 4'h0;
`ifdef FWD_REPLICATOR_STATS_EN
                {sf_a, sd_a, st_a, sf_b, sd_b, st_b} = '0;
`endif
            end
            while ($urandom_range(99) < pe) begin
                cyc(9'($urandom), 1'b1);
                n_chk++;
                if ({o_rd_a, o_rd_b, o_wa, o_wb} !== 10'h0) begin
                    n_fail++;
                    $display("FAIL empty_cycle i=%0d got rd=%b%b wr=%h/%h want 0", i, o_rd_a, o_rd_b, o_wa, o_wb);
                end
            end
            if (i == chg_at) begin
                cmd_fwd_port = cv;
                tx_afull = av;
            end
            w = (i < n) ? {1'b1, 8'($urandom)} : {1'b0, 8'($urandom)};
            cyc(w, 1'b0);
            if (i < n) begin
                ea = (ma != 0 && i <= LA) ? ma : 4'h0;
                eb = (mb != 0 && i <= LB) ? mb : 4'h0;
                xa = (i < LA) ? w : 9'h000;
                xb = (i < LB) ? w : 9'h000;
            end else begin
                ea = (i == n && ma != 0 && n <= LA) ? ma : 4'h0;
                eb = (i == n && mb != 0 && n <= LB) ? mb : 4'h0;
                xa = w;
                xb = w;
            end
            n_chk++;
            if ({o_rd_a, o_rd_b} !== 2'b11) begin
                n_fail++;
                $display("FAIL rd_en i=%0d got %b%b want 11", i, o_rd_a, o_rd_b);
            end
            n_chk++;
            if (o_wa !== ea || (ea != 0 && o_da !== xa)) begin
                n_fail++;
                $display("FAIL write_a i=%0d n=%0d got wr=%h din=%h want wr=%h din=%h", i, n, o_wa, o_da, ea, xa);
            end
            n_chk++;
            if (o_wb !== eb || (eb != 0 && o_db !== xb)) begin
                n_fail++;
                $display("FAIL write_b i=%0d n=%0d got wr=%h din=%h want wr=%h din=%h", i, n, o_wb, o_db, eb, xb);
            end
        end
        syncing = 1'b0;
`ifdef FWD_REPLICATOR_STATS_EN
        if (!sy) begin
            if (ma == 0) sd_a++; else begin sf_a++; if (n > LA) st_a++; end
            if (mb == 0) sd_b++; else begin sf_b++; if (n > LB) st_b++; end
        end
        n_chk++;
        if ({s_fwd_a, s_drop_a, s_trunc_a, s_fwd_b, s_drop_b, s_trunc_b} !== {sf_a, sd_a, st_a, sf_b, sd_b, st_b}) begin
            n_fail++;
            $display("FAIL stats got a=%0d/%0d/%0d b=%0d/%0d/%0d want a=%0d/%0d/%0d b=%0d/%0d/%0d",
                     s_fwd_a, s_drop_a, s_trunc_a, s_fwd_b, s_drop_b, s_trunc_b, sf_a, sd_a, st_a, sf_b, sd_b, st_b);
        end
`endif
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        rx_empty = 1'b0;
        rx_dout = 9'h1AA;
        #1;
        n_chk++;
        if ({rd_a, rd_b, wr_a, wr_b, din_a, din_b} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_values got rd=%b%b wr=%h/%h din=%h/%h want all zero", rd_a, rd_b, wr_a, wr_b, din_a, din_b);
        end
`ifdef FWD_REPLICATOR_STATS_EN
        {sf_a, sd_a, st_a, sf_b, sd_b, st_b} = '0;
        n_chk++;
        if ({s_fwd_a, s_drop_a, s_trunc_a, s_fwd_b, s_drop_b, s_trunc_b} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_stats got nonzero %h want 0", {s_fwd_a, s_drop_a, s_trunc_a});
        end
`endif
        rx_empty = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        syncing = 1'b1;
    endtask

    task automatic test_sync();
        cmd_fwd_port = 16'h0006;
        tx_afull = 4'h0;
        clear_cnt();
        send_frame(3, 0, 0, -1, 16'h0, 4'h0, -1);
        n_chk++;
        if (cnt_a[1] + cnt_a[2] + cnt_b[1] + cnt_b[2] != 0) begin
            n_fail++;
            $display("FAIL sync_discard got %0d writes want 0", cnt_a[1] + cnt_a[2] + cnt_b[1] + cnt_b[2]);
        end
        send_frame(2, 0, 0, -1, 16'h0, 4'h0, -1);
        n_chk++;
        if (cnt_a[1] != 3 || cnt_a[2] != 3 || cnt_a[0] != 0 || cnt_a[3] != 0) begin
            n_fail++;
            $display("FAIL sync_next got %0d/%0d/%0d/%0d want 0/3/3/0", cnt_a[0], cnt_a[1], cnt_a[2], cnt_a[3]);
        end
    endtask

    task automatic test_mask();
        cmd_fwd_port = 16'h0B0F;
        tx_afull = 4'h2;
        clear_cnt();
        send_frame(64, 20, 2, -1, 16'h0, 4'h0, -1);
        n_chk++;
        if (cnt_b[0] != 65 || cnt_b[1] != 0 || cnt_b[2] != 0 || cnt_b[3] != 65) begin
            n_fail++;
            $display("FAIL mask_b got %0d/%0d/%0d/%0d want 65/0/0/65", cnt_b[0], cnt_b[1], cnt_b[2], cnt_b[3]);
        end
        n_chk++;
        if (cnt_a[1] != 0 || cnt_a[0] != 65) begin
            n_fail++;
            $display("FAIL mask_a got p0=%0d p1=%0d want 65/0", cnt_a[0], cnt_a[1]);
        end
    endtask

    task automatic test_drop();
        cmd_fwd_port = 16'h0000;
        tx_afull = 4'h0;
        clear_cnt();
        send_frame(20, 30, 1, -1, 16'h0, 4'h0, -1);
        cmd_fwd_port = 16'h0F0F;
        tx_afull = 4'hF;
        send_frame(5, 0, 0, 2, 16'h0F0F, 4'h0, -1);
        n_chk++;
        if (cnt_a[0] + cnt_a[1] + cnt_a[2] + cnt_a[3] + cnt_b[0] + cnt_b[1] + cnt_b[2] + cnt_b[3] != 0) begin
            n_fail++;
            $display("FAIL drop_writes got nonzero write count want 0");
        end
    endtask

    task automatic test_trunc();
        cmd_fwd_port = 16'h0101;
        tx_afull = 4'h0;
        clear_cnt();
        send_frame(100, 10, 0, -1, 16'h0, 4'h0, -1);
        n_chk++;
        if (cnt_a[0] != 65 || cnt_b[0] != 101) begin
            n_fail++;
            $display("FAIL trunc_count got a=%0d b=%0d want 65/101", cnt_a[0], cnt_b[0]);
        end
        send_frame(10, 10, 1, -1, 16'h0, 4'h0, -1);
    endtask

    task automatic test_freeze();
        cmd_fwd_port = 16'h0101;
        tx_afull = 4'h0;
        clear_cnt();
        send_frame(15, 0, 0, 10, 16'h0202, 4'h1, -1);
        tx_afull = 4'h0;
        send_frame(8, 0, 0, -1, 16'h0, 4'h0, -1);
        n_chk++;
        if (cnt_a[0] != 16 || cnt_a[1] != 9) begin
            n_fail++;
            $display("FAIL freeze got p0=%0d p1=%0d want 16/9", cnt_a[0], cnt_a[1]);
        end
    endtask

    task automatic test_reset_mid();
        cmd_fwd_port = 16'h0303;
        tx_afull = 4'h0;
        send_frame(12, 0, 0, -1, 16'h0, 4'h0, 5);
        send_frame(12, 15, 0, -1, 16'h0, 4'h0, -1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            cmd_fwd_port = 16'($urandom);
            tx_afull = 4'h0;
            send_frame($urandom_range(70, 1), 0, 0, -1, 16'h0, 4'h0, -1);
        end
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 40; k++) begin
            cmd_fwd_port = 16'($urandom);
            tx_afull = 4'($urandom);
            n = $urandom_range(130, 1);
            send_frame(n, 25, $urandom_range(2), ($urandom_range(1) != 0) ? $urandom_range(n, 1) : -1,
                       16'($urandom), 4'($urandom), -1);
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_mask();
        test_drop();
        test_trunc();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
